// File: rtl/over_screen_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : over_screen_writer                                                |
// | Brief  : Game-over overlay raster scanner; reads the sprite ROM and queues |
// |          opaque pixels to the frame buffer over a ready/valid port.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module over_screen_writer #(
  parameter int                 SCREEN_W    = 640,
  parameter int                 SCREEN_H    = 480,
  parameter int                 ROM_LAT     = 2,
  parameter int                 FIFO_DEPTH  = 4,
  parameter int                 COLOR_W     = 4,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
  input  logic               Clk50,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic [2:0]         over_on_wr,
  input  logic [17:0]        sprite_addr,
  output logic [9:0]         WriteX,
  output logic [9:0]         WriteY,
  output logic [17:0]        rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic [18:0]        fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               frame_done
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_INF_W = $clog2(ROM_LAT + 1);
  localparam int c_SUM_W = $clog2(FIFO_DEPTH + ROM_LAT + 1);

  localparam logic [9:0]         c_X_LAST   = 10'(SCREEN_W - 1);
  localparam logic [9:0]         c_Y_LAST   = 10'(SCREEN_H - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic [18:0]        r_pix_addr;
  logic               r_busy;
  logic               r_frame_done;

  logic               r_tag_valid [ROM_LAT];
  logic               r_tag_keep  [ROM_LAT];
  logic [18:0]        r_tag_addr  [ROM_LAT];

  logic [18:0]        r_fifo_addr [FIFO_DEPTH];
  logic [COLOR_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [c_INF_W-1:0] w_inflight;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_not_empty;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + c_INF_W'(r_tag_valid[i]);
    end
  end

  // Credits cover both queued writes and reads still in the ROM pipe, so a
  // tag leaving the pipe always finds a free FIFO slot.
  assign w_issue = (r_state == S_SCAN) &&
                   ((c_SUM_W'(r_count) + c_SUM_W'(w_inflight)) < c_SUM_W'(FIFO_DEPTH));

  assign w_push      = r_tag_valid[ROM_LAT-1] && r_tag_keep[ROM_LAT-1] &&
                       (rom_data != TRANSPARENT);
  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty && fb_ready;

  // Scan / control state machine
  always_ff @(posedge Clk50 or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_pix_addr   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state    <= S_SCAN;
            r_busy     <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_pix_addr <= '0;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            r_pix_addr <= r_pix_addr + 19'd1;
            if (r_x == c_X_LAST) begin
              r_x <= '0;
              if (r_y == c_Y_LAST) begin
                r_y     <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_y <= r_y + 10'd1;
              end
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        S_DRAIN: begin
          if ((w_inflight == '0) && !w_not_empty) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipe mirrors the ROM latency; linear pixel index is the fb address.
  always_ff @(posedge Clk50 or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_tag_valid[i] <= 1'b0;
        r_tag_keep[i]  <= 1'b0;
        r_tag_addr[i]  <= '0;
      end
    end else begin
      r_tag_valid[0] <= w_issue;
      r_tag_keep[0]  <= (over_on_wr != 3'd0);
      r_tag_addr[0]  <= r_pix_addr;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_keep[i]  <= r_tag_keep[i-1];
        r_tag_addr[i]  <= r_tag_addr[i-1];
      end
    end
  end

  always_ff @(posedge Clk50 or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge Clk50) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_tag_addr[ROM_LAT-1];
      r_fifo_data[r_wr_ptr] <= rom_data;
    end
  end

  assign WriteX     = r_x;
  assign WriteY     = r_y;
  assign rom_addr   = sprite_addr;
  assign fb_we      = w_not_empty;
  assign fb_addr    = w_not_empty ? r_fifo_addr[r_rd_ptr] : '0;
  assign fb_data    = w_not_empty ? r_fifo_data[r_rd_ptr] : '0;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_over_screen_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_over_screen_writer                                             |
// | Brief  : Directed bench for over_screen_writer on a reduced 16x8 screen.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_over_screen_writer;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int N     = W * H;

  logic          Clk50       = 1'b0;
  logic          Reset       = 1'b0;
  logic          frame_start = 1'b0;
  logic          fb_ready    = 1'b1;
  logic [2:0]    over_on_wr;
  logic [17:0]   sprite_addr;
  logic [9:0]    WriteX;
  logic [9:0]    WriteY;
  logic [17:0]   rom_addr;
  logic [CW-1:0] rom_p1   = '0;
  logic [CW-1:0] rom_data = '0;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [CW-1:0] fb_data;
  logic          busy;
  logic          frame_done;

  int          mode     = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  int          n_exp    = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  over_screen_writer #(
    .SCREEN_W   (W),
    .SCREEN_H   (H),
    .ROM_LAT    (LAT),
    .FIFO_DEPTH (DEPTH),
    .COLOR_W    (CW),
    .TRANSPARENT(4'd0)
  ) dut (
    .Clk50      (Clk50),
    .Reset      (Reset),
    .frame_start(frame_start),
    .over_on_wr (over_on_wr),
    .sprite_addr(sprite_addr),
    .WriteX     (WriteX),
    .WriteY     (WriteY),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 Clk50 = ~Clk50;
  always @(posedge Clk50) cyc <= cyc + 1;

  // Mode 1: single pixel at (5,3). Mode 2: rows 2..3 opaque except (6,2).
  function automatic bit pix_on(input int m, input int x, input int y);
    case (m)
      1:       return (x == 5) && (y == 3);
      2:       return (y == 2) || (y == 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] pix_color(input int m, input int x, input int y);
    if (m == 1) return 4'd5;
    if ((x == 6) && (y == 2)) return 4'd0;
    return 4'((x + y) % 15 + 1);
  endfunction

  // Overlay address generator and 2-clock sprite ROM
  always_comb begin
    over_on_wr  = 3'd0;
    if (pix_on(mode, int'(WriteX), int'(WriteY))) over_on_wr = (WriteY == 10'd3) ? 3'd4 : 3'd1;
    sprite_addr = 18'(int'(WriteY) * 64 + int'(WriteX));
  end

  always @(posedge Clk50) begin
    rom_p1   <= pix_color(mode, int'(rom_addr) % 64, int'(rom_addr) / 64);
    rom_data <= rom_p1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_expected(input int m);
    exp_q.delete();
    if (m == 1) begin
      exp_q.push_back((32'd5 << 19) | 32'd53);  // (5,3) -> 3*16+5
    end else if (m == 2) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (pix_on(m, x, y) && (pix_color(m, x, y) != 4'd0))
            exp_q.push_back((32'(pix_color(m, x, y)) << 19) | 32'(y * W + x));
    end
    n_exp    = exp_q.size();
    n_writes = 0;
  endtask

  always @(negedge Clk50) begin
    if (Reset && fb_we && fb_ready) begin
      n_writes++;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("fb_addr", 32'(fb_addr), 32'(mon_e[18:0]));
        check_eq("fb_data", 32'(fb_data), 32'(mon_e[22:19]));
      end
    end
  end

  task automatic start_pass();
    @(posedge Clk50); #1 frame_start = 1'b1; t_start = cyc;
    @(posedge Clk50); #1 frame_start = 1'b0;
  endtask

  // Returns at the negedge of the frame_done cycle (or after the budget).
  task automatic wait_done(output int lat);
    int k;
    lat = -1;
    k   = 0;
    while (lat < 0 && k < 3000) begin
      @(negedge Clk50);
      if (frame_done) lat = cyc - t_start;
      k++;
    end
    check_eq("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic run_pass(input int m, input string tag);
    int lat;
    mode = m;
    build_expected(m);
    start_pass();
    wait_done(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(N + LAT + 2));
    check_eq({tag, "_writes"}, 32'(n_writes), 32'(n_exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    logic [9:0] wx, wy;

    repeat (3) @(posedge Clk50);
    @(negedge Clk50);
    check_eq("rst_WriteX", 32'(WriteX), 32'd0);
    check_eq("rst_WriteY", 32'(WriteY), 32'd0);
    check_eq("rst_fb_we", 32'(fb_we), 32'd0);
    check_eq("rst_fb_addr", 32'(fb_addr), 32'd0);
    check_eq("rst_fb_data", 32'(fb_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'(sprite_addr));
    @(posedge Clk50); #1 Reset = 1'b1;

    // Nothing to draw, a single pixel, and a region with one transparent hole.
    run_pass(0, "empty");
    run_pass(1, "single");
    run_pass(2, "region");

    // Back-pressure during the opaque region.
    mode = 2;
    build_expected(2);
    start_pass();
    k = 0;
    @(negedge Clk50);
    while (!fb_we && k < 500) begin @(negedge Clk50); k++; end
    check_eq("stall_we_seen", 32'(fb_we), 32'd1);
    @(posedge Clk50); #1 fb_ready = 1'b0;
    wx = '0; wy = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk50);
      check_eq("stall_we", 32'(fb_we), 32'd1);
      check_eq("stall_head", 32'(fb_addr), 32'(exp_q[0][18:0]));
      if (i == 10) begin wx = WriteX; wy = WriteY; end
    end
    check_eq("stall_scan_x", 32'(WriteX), 32'(wx));
    check_eq("stall_scan_y", 32'(WriteY), 32'(wy));
    @(posedge Clk50); #1 fb_ready = 1'b1;
    wait_done(lat);
    check_eq("stall_writes", 32'(n_writes), 32'(n_exp));

    // Asynchronous reset in the middle of a scan.
    mode = 2;
    build_expected(2);
    start_pass();
    k = 0;
    @(negedge Clk50);
    while (!(WriteX == 10'd8 && WriteY == 10'd3) && k < 500) begin @(negedge Clk50); k++; end
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    check_eq("pre_reset_we", 32'(fb_we), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check_eq("midrst_WriteX", 32'(WriteX), 32'd0);
    check_eq("midrst_WriteY", 32'(WriteY), 32'd0);
    check_eq("midrst_fb_we", 32'(fb_we), 32'd0);
    check_eq("midrst_fb_addr", 32'(fb_addr), 32'd0);
    check_eq("midrst_fb_data", 32'(fb_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_frame_done", 32'(frame_done), 32'd0);
    @(posedge Clk50); #1 Reset = 1'b1;
    run_pass(1, "after_reset");

    // frame_start during SCAN and on the DONE cycle is ignored.
    mode = 1;
    build_expected(1);
    start_pass();
    repeat (40) @(posedge Clk50);
    #1 frame_start = 1'b1;
    @(posedge Clk50); #1 frame_start = 1'b0;
    wait_done(lat);
    check_eq("ignore_scan_latency", 32'(lat), 32'(N + LAT + 2));
    check_eq("ignore_scan_writes", 32'(n_writes), 32'(n_exp));
    check_eq("done_cycle_busy", 32'(busy), 32'd1);
    #1 frame_start = 1'b1;
    @(negedge Clk50);
    check_eq("done_start_ignored", 32'(busy), 32'd0);
    build_expected(1);
    t_start = cyc;
    @(posedge Clk50); #1 frame_start = 1'b0;
    @(negedge Clk50);
    check_eq("idle_start_accepted", 32'(busy), 32'd1);
    wait_done(lat);
    check_eq("restart_latency", 32'(lat), 32'(N + LAT + 2));
    check_eq("restart_writes", 32'(n_writes), 32'(n_exp));
    @(negedge Clk50);
    check_eq("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
